crank_axi_slave: RTL and testbench

AXI4-Lite responder for the crank sensor IP; it is the slave end of the bus that the PS/VIP master drives. It holds four read/write configuration registers and measures the crank tooth period and tooth count from the synchronised crank input. Status is exposed as read-only registers.

---
 rtl/crank_axi_slave.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_crank_axi_slave.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crank_axi_slave.sv
//------------------------------------------------------------------------------
// crank_axi_slave
//
// AXI4-Lite slave for the crank sensor IP. It holds four read/write
// configuration registers and measures the crank tooth period and tooth count
// from a synchronised copy of the raw crank input.
//
// Register map (word index = ADDR[4:2]):
//   0x00 CTRL      RW  bit0 EN enables capture
//   0x04 REG1      RW
//   0x08 REG2      RW
//   0x0C REG3      RW
//   0x10 PERIOD    RO  cycles between the last two captured rising edges
//   0x14 TOOTH_CNT RO  captured edge count; any write clears it
//   0x18, 0x1C         read 0, writes ignored
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN   clock (rising edge) and async active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*   write address, data and response channels
//   S_AXI_AR* / S_AXI_R*              read address and data channels
//   crank_in                    raw asynchronous crank tooth signal
//   cfg_ctrl, cfg_reg1..3       current values of CTRL and REG1..REG3
//   irq                         (CRANK_IRQ_EN only) set on each captured edge,
//                               cleared by writing 0x10 with WDATA[0] = 1
//
// Build option: define CRANK_IRQ_EN to add the irq output. Without it a write
// to 0x10 has no effect.
//------------------------------------------------------------------------------
module crank_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            crank_in,
`ifdef CRANK_IRQ_EN
  output logic                            irq,
`endif
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_ctrl,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg3
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DW / 8;

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_REG1   = 3'd1;
  localparam logic [2:0] IDX_REG2   = 3'd2;
  localparam logic [2:0] IDX_REG3   = 3'd3;
  localparam logic [2:0] IDX_PERIOD = 3'd4;
  localparam logic [2:0] IDX_TOOTH  = 3'd5;

  localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};
  localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  // Merge new data into an old word, one byte lane per strobe bit.
  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0]     old_val,
                                               input logic [DW-1:0]     new_val,
                                               input logic [STRB_W-1:0] strb);
    logic [DW-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
    logic [DW-1:0] res;
    if (v == ALL_ONES) begin
      res = ALL_ONES;
    end else begin
      res = v + ONE;
    end
    return res;
  endfunction

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic            wr_fire_s;
  logic            rd_fire_s;
  logic [2:0]      wr_idx_s;
  logic [2:0]      rd_idx_s;

  logic [DW-1:0]   ctrl_q, ctrl_d;
  logic [DW-1:0]   reg1_q, reg1_d;
  logic [DW-1:0]   reg2_q, reg2_d;
  logic [DW-1:0]   reg3_q, reg3_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            sync1_q, sync2_q, sync3_q;
  logic            cap_s;
  logic            tooth_clr_s;
  logic [DW-1:0]   count_q, count_d;
  logic [DW-1:0]   period_q, period_d;
  logic [DW-1:0]   tooth_q, tooth_d;

  // Inputs that carry no information for this slave.
  logic unused_inputs_s;
  assign unused_inputs_s = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_idx_s = S_AXI_AWADDR[4:2];
  assign rd_idx_s = S_AXI_ARADDR[4:2];

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign S_AXI_RDATA = rdata_q;

  assign cfg_ctrl = ctrl_q;
  assign cfg_reg1 = reg1_q;
  assign cfg_reg2 = reg2_q;
  assign cfg_reg3 = reg3_q;

  //----------------------------------------------------------------------------
  // Write channel FSM
  //----------------------------------------------------------------------------

  // Write FSM state register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
    end else begin
      w_state_q <= w_state_d;
    end
  end

  // Write FSM next state: address and data are only taken together.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID) begin
          w_state_d = W_RESP;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs: both READYs pulse in the cycle the write is committed.
  always_comb begin
    wr_fire_s    = 1'b0;
    S_AXI_BVALID = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        wr_fire_s    = S_AXI_AWVALID & S_AXI_WVALID;
        S_AXI_BVALID = 1'b0;
      end
      W_RESP: begin
        wr_fire_s    = 1'b0;
        S_AXI_BVALID = 1'b1;
      end
      default: begin
        wr_fire_s    = 1'b0;
        S_AXI_BVALID = 1'b0;
      end
    endcase
    S_AXI_AWREADY = wr_fire_s;
    S_AXI_WREADY  = wr_fire_s;
  end

  //----------------------------------------------------------------------------
  // Read channel FSM
  //----------------------------------------------------------------------------

  // Read FSM state register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_q <= R_IDLE;
    end else begin
      r_state_q <= r_state_d;
    end
  end

  // Read FSM next state.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID) begin
          r_state_d = R_DATA;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM outputs.
  always_comb begin
    rd_fire_s    = 1'b0;
    S_AXI_RVALID = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        rd_fire_s    = S_AXI_ARVALID;
        S_AXI_RVALID = 1'b0;
      end
      R_DATA: begin
        rd_fire_s    = 1'b0;
        S_AXI_RVALID = 1'b1;
      end
      default: begin
        rd_fire_s    = 1'b0;
        S_AXI_RVALID = 1'b0;
      end
    endcase
    S_AXI_ARREADY = rd_fire_s;
  end

  // Read data mux: sampled from the current (pre-write) register values, so a
  // read that coincides with a write to the same register returns old data.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_fire_s) begin
      case (rd_idx_s)
        IDX_CTRL:   rdata_d = ctrl_q;
        IDX_REG1:   rdata_d = reg1_q;
        IDX_REG2:   rdata_d = reg2_q;
        IDX_REG3:   rdata_d = reg3_q;
        IDX_PERIOD: rdata_d = period_q;
        IDX_TOOTH:  rdata_d = tooth_q;
        default:    rdata_d = {DW{1'b0}};
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rdata_q <= {DW{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  //----------------------------------------------------------------------------
  // Configuration registers
  //----------------------------------------------------------------------------

  // Byte-lane write into the addressed RW register.
  always_comb begin
    ctrl_d = ctrl_q;
    reg1_d = reg1_q;
    reg2_d = reg2_q;
    reg3_d = reg3_q;
    if (wr_fire_s) begin
      case (wr_idx_s)
        IDX_CTRL: ctrl_d = apply_strb(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB);
        IDX_REG1: reg1_d = apply_strb(reg1_q, S_AXI_WDATA, S_AXI_WSTRB);
        IDX_REG2: reg2_d = apply_strb(reg2_q, S_AXI_WDATA, S_AXI_WSTRB);
        IDX_REG3: reg3_d = apply_strb(reg3_q, S_AXI_WDATA, S_AXI_WSTRB);
        default: begin
          ctrl_d = ctrl_q;
          reg1_d = reg1_q;
          reg2_d = reg2_q;
          reg3_d = reg3_q;
        end
      endcase
    end else begin
      ctrl_d = ctrl_q;
      reg1_d = reg1_q;
      reg2_d = reg2_q;
      reg3_d = reg3_q;
    end
  end

  // Configuration register storage.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q <= {DW{1'b0}};
      reg1_q <= {DW{1'b0}};
      reg2_q <= {DW{1'b0}};
      reg3_q <= {DW{1'b0}};
    end else begin
      ctrl_q <= ctrl_d;
      reg1_q <= reg1_d;
      reg2_q <= reg2_d;
      reg3_q <= reg3_d;
    end
  end

  //----------------------------------------------------------------------------
  // Crank capture
  //----------------------------------------------------------------------------

  // Two-flop synchroniser plus a third flop for rising-edge detection.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= crank_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign cap_s       = ctrl_q[0] & sync2_q & ~sync3_q;
  assign tooth_clr_s = wr_fire_s & (wr_idx_s == IDX_TOOTH);

  // Period counter, captured period and tooth count. The counter is held at
  // zero while disabled so the first captured period after enabling counts
  // from the enable point. A clear write beats a simultaneous edge.
  always_comb begin
    count_d  = count_q;
    period_d = period_q;
    tooth_d  = tooth_q;
    if (!ctrl_q[0]) begin
      count_d = {DW{1'b0}};
    end else if (cap_s) begin
      count_d  = {DW{1'b0}};
      period_d = sat_inc(count_q);
    end else begin
      count_d = sat_inc(count_q);
    end
    if (tooth_clr_s) begin
      tooth_d = {DW{1'b0}};
    end else if (cap_s) begin
      tooth_d = tooth_q + ONE;
    end else begin
      tooth_d = tooth_q;
    end
  end

  // Capture registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      count_q  <= {DW{1'b0}};
      period_q <= {DW{1'b0}};
      tooth_q  <= {DW{1'b0}};
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
      tooth_q  <= tooth_d;
    end
  end

`ifdef CRANK_IRQ_EN
  logic irq_q, irq_d;
  logic irq_clr_s;

  assign irq_clr_s = wr_fire_s & (wr_idx_s == IDX_PERIOD) & S_AXI_WDATA[0];
  assign irq       = irq_q;

  // Sticky interrupt; a new edge beats a simultaneous clear.
  always_comb begin
    irq_d = irq_q;
    if (cap_s) begin
      irq_d = 1'b1;
    end else if (irq_clr_s) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // Interrupt flag register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end
`endif

endmodule

// File: tb/tb_crank_axi_slave.sv
module tb_crank_axi_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        crank_in;
  logic [31:0] cfg_ctrl, cfg_reg1, cfg_reg2, cfg_reg3;
`ifdef CRANK_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  logic [31:0] m_reg [0:3];
  int          m_period;
  bit          m_period_valid;
  int          m_tooth;
  int          m_last_rise;
  bit          m_rise_valid;
  bit          m_irq;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crank_axi_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .crank_in      (crank_in),
`ifdef CRANK_IRQ_EN
    .irq           (irq),
`endif
    .cfg_ctrl      (cfg_ctrl),
    .cfg_reg1      (cfg_reg1),
    .cfg_reg2      (cfg_reg2),
    .cfg_reg3      (cfg_reg3)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
    m_period       = 0;
    m_period_valid = 1'b1;
    m_tooth        = 0;
    m_last_rise    = 0;
    m_rise_valid   = 1'b0;
    m_irq          = 1'b0;
  endtask

  task automatic model_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] mask;
    int          idx;
    bit          old_en;
    idx    = int'(addr[4:2]);
    mask   = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    old_en = m_reg[0][0];
    if (idx < 4) begin
      m_reg[idx] = (m_reg[idx] & ~mask) | (data & mask);
      if (idx == 0 && !(old_en && m_reg[0][0])) m_rise_valid = 1'b0;
    end else if (idx == 5) begin
      m_tooth = 0;
    end else if (idx == 4) begin
`ifdef CRANK_IRQ_EN
      if (data[0]) m_irq = 1'b0;
`endif
    end
  endtask

  // A rising crank_in transition as seen by the model.
  task automatic model_rise();
    if (m_reg[0][0]) begin
      m_tooth = m_tooth + 1;
      if (m_rise_valid) begin
        m_period       = cyc - m_last_rise;
        m_period_valid = 1'b1;
      end else begin
        m_period_valid = 1'b0;
      end
      m_last_rise  = cyc;
      m_rise_valid = 1'b1;
      m_irq        = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    case (addr[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: return m_reg[int'(addr[4:2])];
      3'd4: return 32'(m_period);
      3'd5: return 32'(m_tooth);
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- bus tasks (start and end at a falling edge) ----------------
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    #1;
    while (!(awready && wready) && n < 20) begin @(negedge clk); #1; n++; end
    check1("wr_ready", awready & wready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(addr, data, strb);
    #1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); #1; n++; end
    check1("bvalid", bvalid, 1'b1);
    check32("bresp", {30'h0, bresp}, 32'h0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
    int n;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    #1;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    check1("arready", arready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); #1; n++; end
    check1("rvalid", rvalid, 1'b1);
    check32("rresp", {30'h0, rresp}, 32'h0);
    data = rdata;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_check(input string tag, input logic [4:0] addr);
    logic [31:0] d;
    axi_read(addr, d);
    if (addr[4:2] != 3'd4 || m_period_valid) check32(tag, d, model_read(addr));
  endtask

  // One crank tooth: rise now, next rise exactly gap cycles later.
  task automatic crank_pulse(input int gap);
    crank_in = 1'b1;
    model_rise();
    repeat (gap / 2) @(negedge clk);
    crank_in = 1'b0;
    repeat (gap - gap / 2) @(negedge clk);
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    logic [31:0] d;
    logic [31:0] old_val;
    logic [4:0]  a;
    int          p_keep;

    rst_n = 1'b0;
    awaddr = 5'h0; araddr = 5'h0; awprot = 3'h0; arprot = 3'h0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = 32'h0; wstrb = 4'h0; crank_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    check1("rst_awready", awready, 1'b0);
    check1("rst_bvalid", bvalid, 1'b0);
    check1("rst_rvalid", rvalid, 1'b0);
    check32("rst_rdata", rdata, 32'h0);
    check32("rst_cfg_ctrl", cfg_ctrl, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write / read back
    axi_write(5'h00, 32'h1, 4'hF);
    axi_write(5'h04, 32'h2, 4'hF);
    axi_write(5'h08, 32'h3, 4'hF);
    axi_write(5'h0C, 32'h4, 4'hF);
    for (int i = 0; i < 4; i++) begin
      a = 5'(i * 4);
      axi_read(a, d);
      check32("rd_basic", d, 32'(i + 1));
    end
    check32("cfg_reg3", cfg_reg3, 32'h4);

    // Partial strobe
    axi_write(5'h04, 32'hAABBCCDD, 4'b0010);
    axi_read(5'h04, d);
    check32("strb_reg1", d, 32'h0000CC02);
    check32("strb_model", d, model_read(5'h04));

    // AW ahead of W; then BVALID held while BREADY low
    awaddr = 5'h08; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check1("aw_only_awready", awready, 1'b0);
      check1("aw_only_wready", wready, 1'b0);
      @(negedge clk);
    end
    wvalid = 1'b1;
    #1;
    check1("both_awready", awready, 1'b1);
    check1("both_wready", wready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    model_write(5'h08, 32'h5A5A5A5A, 4'hF);
    awaddr = 5'h0C; wdata = 32'h0000DEAD;   // must not be accepted during BVALID
    for (int i = 0; i < 5; i++) begin
      #1;
      check1("bvalid_hold", bvalid, 1'b1);
      check1("no_accept_in_resp", awready, 1'b0);
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check1("bvalid_drop", bvalid, 1'b0);
    @(negedge clk);
    check32("cfg_reg2_aw_first", cfg_reg2, m_reg[2]);
    check32("cfg_reg3_untouched", cfg_reg3, m_reg[3]);

    // Same-cycle write and read of REG2 returns the old value
    old_val = m_reg[2];
    awaddr = 5'h08; wdata = 32'h12345678; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 5'h08; arvalid = 1'b1; rready = 1'b1;
    #1;
    check1("rw_awready", awready, 1'b1);
    check1("rw_arready", arready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model_write(5'h08, 32'h12345678, 4'hF);
    #1;
    check1("rw_rvalid", rvalid, 1'b1);
    check1("rw_bvalid", bvalid, 1'b1);
    check32("rw_old_data", rdata, old_val);
    check32("rw_cfg_reg2", cfg_reg2, 32'h12345678);
    @(negedge clk);

    // Randomized register traffic against the model
    for (int i = 0; i < 12; i++) begin
      a = {3'($urandom_range(0, 7)), 2'b00};
      axi_write(a, 32'($urandom), 4'($urandom));
    end
    for (int i = 0; i < 8; i++) read_check("rand_rd", {3'(i), 2'b00});
    check32("rand_cfg_ctrl", cfg_ctrl, m_reg[0]);
    check32("rand_cfg_reg1", cfg_reg1, m_reg[1]);

    // Crank capture: 4 edges 100 cycles apart
    axi_write(5'h00, 32'h1, 4'hF);
    axi_write(5'h14, 32'h0, 4'hF);
    repeat (4) crank_pulse(100);
    axi_read(5'h10, d);
    check32("period_100", d, 32'd100);
    axi_read(5'h14, d);
    check32("tooth_4", d, 32'd4);
    axi_write(5'h14, 32'h0, 4'hF);
    axi_read(5'h14, d);
    check32("tooth_clear", d, 32'h0);

    // Randomized tooth spacing
    for (int i = 0; i < 5; i++) crank_pulse(int'($urandom_range(8, 120)));
    read_check("rand_period", 5'h10);
    read_check("rand_tooth", 5'h14);

    // Clear write landing on the same edge as a capture: clear wins
    crank_in = 1'b1;
    model_rise();
    @(negedge clk);
    @(negedge clk);
    axi_write(5'h14, 32'h0, 4'hF);
    crank_in = 1'b0;
    repeat (4) @(negedge clk);
    axi_read(5'h14, d);
    check32("clear_beats_edge", d, 32'h0);
    read_check("period_on_clear", 5'h10);

`ifdef CRANK_IRQ_EN
    check1("irq_set", irq, m_irq);
    axi_read(5'h10, d);
    p_keep = int'(d);
    axi_write(5'h10, 32'h1, 4'hF);
    check1("irq_clear", irq, 1'b0);
    axi_read(5'h10, d);
    check32("irq_period_kept", d, 32'(p_keep));
`else
    p_keep = 0;
`endif

    // EN = 0: edges ignored
    axi_write(5'h00, 32'h0, 4'hF);
    repeat (3) crank_pulse(12);
    repeat (4) @(negedge clk);
    read_check("en0_period", 5'h10);
    read_check("en0_tooth", 5'h14);

    // Reset in the middle of a read with RVALID high
    araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
    #1;
    check1("mid_arready", arready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    check1("mid_rvalid", rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("rst_drops_rvalid", rvalid, 1'b0);
    check32("rst_cfg_reg1", cfg_reg1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) read_check("post_rst_rd", {3'(i), 2'b00});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
